univ_shift_reg_burst: RTL and testbench

- Parametrised successor to the 8-bit universal shift register: generic WIDTH with eight operating modes (hold, logical shift right/left, parallel load, rotate right/left, arithmetic shift right, synchronous clear).
- Adds a burst sequencer: one START command performs an N-position shift autonomously, with BUSY/DONE handshake.
- Used as the shift/rotate engine in register-move datapaths and serial converters.

---
 rtl/univ_shift_reg_burst_if.sv | 29 ++
 rtl/univ_shift_reg_burst.sv | 107 ++++++++++
 tb/tb_univ_shift_reg_burst.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/univ_shift_reg_burst_if.sv
// Command/status bundle for the universal shift register with burst sequencer.
// The master drives commands and serial inputs; the slave (the register) returns Q and the handshake.
interface univ_shift_reg_burst_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
);
    logic             EN;
    logic [2:0]       MODE;
    logic [WIDTH-1:0] D;
    logic             SL;
    logic             SR;
    logic             START;
    logic [CNT_W-1:0] CNT;
    logic [WIDTH-1:0] Q;
    logic             SO_R;
    logic             SO_L;
    logic             BUSY;
    logic             DONE;

    modport master (
        output EN, MODE, D, SL, SR, START, CNT,
        input  Q, SO_R, SO_L, BUSY, DONE
    );

    modport slave (
        input  EN, MODE, D, SL, SR, START, CNT,
        output Q, SO_R, SO_L, BUSY, DONE
    );
endinterface

// File: rtl/univ_shift_reg_burst.sv
// WIDTH-bit universal shift register (8 modes) with an autonomous N-position burst sequencer.
// A START with a shift-class mode latches MODE/CNT; the burst then runs with BUSY high and ends with a one-cycle DONE.
module univ_shift_reg_burst #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input logic CP,
    input logic CR,
    univ_shift_reg_burst_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [2:0]       mode_q, mode_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    function automatic logic is_shift(input logic [2:0] m);
        return (m == 3'b001) || (m == 3'b010) || (m == 3'b100) ||
               (m == 3'b101) || (m == 3'b110);
    endfunction

    function automatic logic [WIDTH-1:0] apply_mode(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] r;
        case (m)
            3'b001:  r = {sr, q[WIDTH-1:1]};
            3'b010:  r = {q[WIDTH-2:0], sl};
            3'b011:  r = d;
            3'b100:  r = {q[0], q[WIDTH-1:1]};
            3'b101:  r = {q[WIDTH-2:0], q[WIDTH-1]};
            3'b110:  r = {q[WIDTH-1], q[WIDTH-1:1]};
            3'b111:  r = '0;
            default: r = q;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.START && is_shift(bus.MODE)) begin
                    mode_d = bus.MODE;
                    rem_d  = bus.CNT;
                    if (bus.CNT == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end else if (bus.EN) begin
                    q_d = apply_mode(bus.MODE, q_q, bus.D, bus.SL, bus.SR);
                end
            end
            RUN: begin
                // Exit on rem==1 so the down-counter never wraps below zero.
                q_d   = apply_mode(mode_q, q_q, bus.D, bus.SL, bus.SR);
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state_q <= IDLE;
            q_q     <= '0;
            mode_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.Q    = q_q;
    assign bus.SO_R = q_q[0];
    assign bus.SO_L = q_q[WIDTH-1];
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
endmodule

// File: tb/tb_univ_shift_reg_burst.sv
// Bench for univ_shift_reg_burst: single-step vector table, burst corner sequences,
// and a randomized run against a cycle-level behavioural model.
module tb_univ_shift_reg_burst;
    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic CP = 1'b0;
    logic CR = 1'b0;
    int   total = 0;
    int   bad   = 0;

    univ_shift_reg_burst_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    univ_shift_reg_burst #(.WIDTH(W), .CNT_W(CW)) dut (.CP(CP), .CR(CR), .bus(bus));

    always #5 CP = ~CP;

    typedef struct {
        logic [W-1:0] init;
        logic [2:0]   mode;
        logic         en;
        logic         sl;
        logic         sr;
        logic [W-1:0] d;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CP);
        #1;
    endtask

    task automatic idle_inputs();
        bus.EN = 1'b0; bus.MODE = 3'b000; bus.D = '0; bus.SL = 1'b0;
        bus.SR = 1'b0; bus.START = 1'b0; bus.CNT = '0;
    endtask

    task automatic load(input logic [W-1:0] v);
        idle_inputs();
        bus.EN = 1'b1; bus.MODE = 3'b011; bus.D = v;
        step();
        idle_inputs();
    endtask

    // Reference operation, written with shifts and arithmetic rather than bit slices.
    function automatic logic [W-1:0] ref_op(input logic [2:0] m, input logic [W-1:0] q,
                                            input logic [W-1:0] d, input logic sl, input logic sr);
        logic [W-1:0] msb;
        msb = 1 << (W - 1);
        case (m)
            3'd1: return (q >> 1) | (sr ? msb : '0);
            3'd2: return (q << 1) | W'(sl);
            3'd3: return d;
            3'd4: return (q >> 1) | (q << (W - 1));
            3'd5: return (q << 1) | (q >> (W - 1));
            3'd6: return W'($signed(q) >>> 1);
            3'd7: return '0;
            default: return q;
        endcase
    endfunction

    initial begin
        idle_inputs();

        // Asynchronous reset mid-cycle
        CR = 1'b1; #3; CR = 1'b0;
        chk("reset_q0", bus.Q, 0);
        load(8'hA5);
        chk("preload_a5", bus.Q, 8'hA5);
        #2; CR = 1'b1; #1;
        chk("async_rst_q", bus.Q, 0);
        chk("async_rst_busy", bus.BUSY, 0);
        chk("async_rst_done", bus.DONE, 0);
        #1; CR = 1'b0;

        vecs[0] = '{8'h96, 3'b001, 1'b1, 1'b0, 1'b1, 8'h00, 8'hCB};
        vecs[1] = '{8'h96, 3'b010, 1'b1, 1'b0, 1'b0, 8'h00, 8'h2C};
        vecs[2] = '{8'h96, 3'b100, 1'b1, 1'b0, 1'b0, 8'h00, 8'h4B};
        vecs[3] = '{8'h96, 3'b101, 1'b1, 1'b0, 1'b0, 8'h00, 8'h2D};
        vecs[4] = '{8'h80, 3'b110, 1'b1, 1'b0, 1'b0, 8'h00, 8'hC0};
        vecs[5] = '{8'h96, 3'b011, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h3C};
        vecs[6] = '{8'h96, 3'b111, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[7] = '{8'h96, 3'b001, 1'b0, 1'b1, 1'b1, 8'h3C, 8'h96};
        for (int i = 0; i < 8; i++) begin
            load(vecs[i].init);
            bus.EN = vecs[i].en; bus.MODE = vecs[i].mode; bus.SL = vecs[i].sl;
            bus.SR = vecs[i].sr; bus.D = vecs[i].d;
            step();
            chk($sformatf("vec%0d_q", i), bus.Q, vecs[i].exp);
            chk($sformatf("vec%0d_so", i), {bus.SO_L, bus.SO_R}, {vecs[i].exp[W-1], vecs[i].exp[0]});
        end

        // START with a non-shift mode behaves as single-step
        load(8'h11);
        bus.START = 1'b1; bus.EN = 1'b1; bus.MODE = 3'b011; bus.D = 8'h77; bus.CNT = 4'd5;
        step();
        chk("start_load_q", bus.Q, 8'h77);
        chk("start_load_busy", bus.BUSY, 0);
        idle_inputs();

        // Burst rotate-left by 3
        load(8'h81);
        bus.START = 1'b1; bus.MODE = 3'b101; bus.CNT = 4'd3;
        step();
        idle_inputs();
        chk("rol_accept_q", bus.Q, 8'h81);
        chk("rol_accept_busy", bus.BUSY, 1);
        step(); chk("rol_s1", bus.Q, 8'h03); chk("rol_s1_busy", bus.BUSY, 1);
        step(); chk("rol_s2", bus.Q, 8'h06); chk("rol_s2_busy", bus.BUSY, 1);
        step(); chk("rol_s3", bus.Q, 8'h0C); chk("rol_fin_busy", bus.BUSY, 0);
        chk("rol_fin_done", bus.DONE, 1);
        bus.START = 1'b1; bus.MODE = 3'b001; bus.CNT = 4'd2;  // ignored in FIN
        step(); chk("rol_idle_done", bus.DONE, 0); chk("rol_idle_q", bus.Q, 8'h0C);
        chk("fin_start_ignored", bus.BUSY, 0);
        idle_inputs();

        // Burst ASR by 15 with disturbances during BUSY
        load(8'h80);
        bus.START = 1'b1; bus.MODE = 3'b110; bus.CNT = 4'd15;
        step();
        begin
            int n = 0;
            while (!bus.DONE && n < 20) begin
                bus.MODE = 3'($urandom); bus.D = 8'($urandom); bus.START = 1'($urandom);
                bus.EN = 1'($urandom);
                step();
                n++;
            end
            chk("asr_done_seen", bus.DONE, 1);
            chk("asr_shift_count", n, 15);
            chk("asr_result", bus.Q, 8'hFF);
        end
        idle_inputs();
        step();

        // Zero-length burst
        load(8'h5A);
        bus.START = 1'b1; bus.MODE = 3'b001; bus.CNT = 4'd0; bus.SR = 1'b1;
        step();
        idle_inputs();
        chk("cnt0_done", bus.DONE, 1);
        chk("cnt0_busy", bus.BUSY, 0);
        chk("cnt0_q", bus.Q, 8'h5A);
        step();
        chk("cnt0_done_drop", bus.DONE, 0);
        chk("cnt0_q_hold", bus.Q, 8'h5A);

        // Reset mid-burst
        load(8'hFF);
        bus.START = 1'b1; bus.MODE = 3'b010; bus.CNT = 4'd10;
        step();
        idle_inputs();
        for (int i = 0; i < 4; i++) step();
        chk("midrst_pre_q", bus.Q, 8'hF0);
        #2; CR = 1'b1; #1;
        chk("midrst_q", bus.Q, 0);
        chk("midrst_busy", bus.BUSY, 0);
        step(); step();
        CR = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                step();
                if (bus.DONE || bus.BUSY) seen++;
            end
            chk("midrst_no_done", seen, 0);
        end
        load(8'h3C);
        chk("post_rst_load", bus.Q, 8'h3C);

        // Randomized run against the model
        begin
            logic [W-1:0] mq;
            logic [2:0]   lmode;
            int           left;
            logic         fin;
            logic         en, sl, sr, st;
            logic [2:0]   m;
            logic [W-1:0] d;
            logic [CW-1:0] c;
            mq = bus.Q; left = 0; fin = 1'b0; lmode = '0;
            for (int i = 0; i < 400; i++) begin
                en = 1'($urandom); sl = 1'($urandom); sr = 1'($urandom);
                st = ($urandom_range(0, 5) == 0); m = 3'($urandom); d = W'($urandom);
                c = CW'($urandom_range(0, 11));
                bus.EN = en; bus.SL = sl; bus.SR = sr; bus.START = st;
                bus.MODE = m; bus.D = d; bus.CNT = c;
                step();
                if (fin) begin
                    fin = 1'b0;
                end else if (left > 0) begin
                    mq = ref_op(lmode, mq, d, sl, sr);
                    left--;
                    if (left == 0) fin = 1'b1;
                end else if (st && (m inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6})) begin
                    lmode = m;
                    if (c == 0) fin = 1'b1; else left = c;
                end else if (en) begin
                    mq = ref_op(m, mq, d, sl, sr);
                end
                chk("rnd_q", bus.Q, mq);
                chk("rnd_busy", bus.BUSY, left > 0);
                chk("rnd_done", bus.DONE, fin);
                chk("rnd_so", {bus.SO_L, bus.SO_R}, {mq[W-1], mq[0]});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
